fir_coeff_sample_ctrl: RTL
==========================

# fir_coeff_sample_ctrl

Front-end controller for the transposed-form 33-tap FIR datapath: it owns the coefficient bank and paces input samples into the multiply/add/shift stage. Coefficients are written over a simple register bus into a shadow bank and committed to the active bank only after the datapath pipeline has been flushed with zeros, so no output ever mixes two coefficient sets. It drives the datapath's sample input, its accumulate enable and all 33 coefficient inputs.

## Interface
- NUM_TAPS, 33, number of coefficients; must match datapath
- DATA_W, 16, sample and coefficient width (signed)
- ADDR_W, 6, coefficient address width
- iClk_12M  in  1  system clock; all logic on rising edge
- iRsn  in  1  reset; synchronous, active-low
- iCoeffWrEn  in  1  write strobe for shadow coefficient bank
- iCoeffAddr  in  ADDR_W  coefficient index 0..NUM_TAPS-1 (0 = datapath coefficient 1)
- iCoeffData  in  DATA_W  signed coefficient value
- iCoeffUpdate  in  1  one-cycle commit request: shadow -> active after flush
- iSampleValid  in  1  input sample valid
- iSample  in  DATA_W  signed input sample
- oSampleReady  out  1  sample accepted when iSampleValid && oSampleReady
- oFirIn  out  DATA_W  sample to datapath (registered)
- oEnAcc  out  1  datapath accumulate enable (registered)
- oCoeffFlat  out  NUM_TAPS*DATA_W  active bank; coefficient k at bits [16k+15:16k]
- oSwapDone  out  1  one-cycle pulse when active bank is updated
- oCoeffErr  out  1  sticky: write with address >= NUM_TAPS seen

## Operation
- States: RUN, FLUSH, SWAP. Reset -> RUN.
- Reset (iRsn=0 at clock edge): shadow and active banks 0, oFirIn 0, oEnAcc 0, oSwapDone 0, oCoeffErr 0, pending flag 0, flush counter 0.
- oSampleReady = (state == RUN) && !pending; combinational.
- RUN: on handshake, oFirIn <= iSample, oEnAcc <= 1; otherwise oEnAcc <= 0, oFirIn holds. If pending set, next state FLUSH.
- iCoeffUpdate sets pending in any state; ignored if pending already set. A sample handshake in the same cycle as iCoeffUpdate is accepted; oSampleReady drops the next cycle.
- FLUSH: 33 consecutive cycles with oFirIn <= 0, oEnAcc <= 1 (clears all 32 datapath shift registers and its output register). Counter 0..32; at 32 -> SWAP.
- SWAP: one cycle; active bank <= shadow bank, oSwapDone <= 1, oEnAcc <= 0, pending <= 0, counter <= 0; next RUN. iCoeffUpdate in the SWAP cycle wins: pending stays 1 and RUN immediately re-enters FLUSH.
- Coefficient writes accepted in every state. Write in SWAP cycle lands in shadow only; active gets pre-write shadow value.
- Address >= NUM_TAPS: write dropped, oCoeffErr <= 1 until reset.
- Active bank never changes outside SWAP.

## Timing
- Sample latency: handshake at edge N -> oFirIn/oEnAcc valid after edge N, consumed by datapath at edge N+1.
- Throughput: one sample per cycle in RUN with no bubbles.
- Commit cost: iCoeffUpdate at edge N (in RUN, no pending) -> FLUSH cycles N+1..N+33 -> SWAP cycle N+34 -> oSwapDone and new oCoeffFlat visible after edge N+34 -> oSampleReady high again from cycle N+35.
- Reset mid-FLUSH/SWAP: aborts, banks cleared, back to RUN, no swap pulse.

## Test plan
- Reset then idle: all outputs 0, oSampleReady=1, oCoeffFlat=0.
- Write coeff[0]=16'h0100, coeff[32]=16'hFF00, update; stream samples 1,2,3: oSampleReady low exactly 34 cycles, 33 cycles oEnAcc=1 with oFirIn=0, oSwapDone one pulse, oCoeffFlat[15:0]=16'h0100, [527:512]=16'hFF00.
- Back-to-back samples 10,20,30 with valid held: oEnAcc high 3 cycles, oFirIn 10,20,30 one cycle after each handshake.
- Write to address 33 and 63: shadow unchanged, oCoeffErr=1 after first, stays 1; cleared only by iRsn=0.
- iCoeffUpdate during FLUSH ignored (single swap); iCoeffUpdate in SWAP cycle -> second 33-cycle flush and second oSwapDone.
- iRsn=0 at FLUSH cycle 10: next cycle RUN, oEnAcc=0, banks 0, no oSwapDone.

Source files
------------

// File: rtl/fir_coeff_sample_ctrl.sv
// Coefficient bank owner and sample pacer for the 33-tap transposed FIR datapath.
// New coefficients go active only after the datapath has been flushed with zeros.
module fir_coeff_sample_ctrl #(
    parameter int NUM_TAPS = 33,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6
) (
    input  logic                         iClk_12M,
    input  logic                         iRsn,
    input  logic                         iCoeffWrEn,
    input  logic [ADDR_W-1:0]            iCoeffAddr,
    input  logic signed [DATA_W-1:0]     iCoeffData,
    input  logic                         iCoeffUpdate,
    input  logic                         iSampleValid,
    input  logic signed [DATA_W-1:0]     iSample,
    output logic                         oSampleReady,
    output logic signed [DATA_W-1:0]     oFirIn,
    output logic                         oEnAcc,
    output logic [NUM_TAPS*DATA_W-1:0]   oCoeffFlat,
    output logic                         oSwapDone,
    output logic                         oCoeffErr
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_SWAP  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(NUM_TAPS - 1);

    logic [1:0]              state;
    logic                    pending;
    logic [ADDR_W-1:0]       flush_cnt;
    logic signed [DATA_W-1:0] shadow [NUM_TAPS];
    logic signed [DATA_W-1:0] active [NUM_TAPS];
    logic                    handshake;

    assign oSampleReady = (state == ST_RUN) && !pending;
    assign handshake    = iSampleValid && oSampleReady;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
        assign oCoeffFlat[k*DATA_W +: DATA_W] = active[k];
    end

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            state     <= ST_RUN;
            pending   <= 1'b0;
            flush_cnt <= '0;
            oFirIn    <= '0;
            oEnAcc    <= 1'b0;
            oSwapDone <= 1'b0;
            oCoeffErr <= 1'b0;
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            oSwapDone <= 1'b0;

            if (iCoeffWrEn) begin
                if (iCoeffAddr <= LAST_ADDR)
                    shadow[iCoeffAddr] <= iCoeffData;
                else
                    oCoeffErr <= 1'b1;
            end

            if (iCoeffUpdate)
                pending <= 1'b1;

            case (state)
                ST_RUN: begin
                    if (handshake) begin
                        oFirIn <= iSample;
                        oEnAcc <= 1'b1;
                    end else begin
                        oEnAcc <= 1'b0;
                    end
                    // A fresh request flushes from the very next cycle so the
                    // commit finishes 34 edges after the request.
                    if (pending || iCoeffUpdate)
                        state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    oFirIn <= '0;
                    oEnAcc <= 1'b1;
                    if (flush_cnt == FLUSH_LAST)
                        state <= ST_SWAP;
                    else
                        flush_cnt <= flush_cnt + 1'b1;
                end
                ST_SWAP: begin
                    for (int unsigned k = 0; k < NUM_TAPS; k++)
                        active[k] <= shadow[k];
                    oSwapDone <= 1'b1;
                    oEnAcc    <= 1'b0;
                    pending   <= iCoeffUpdate;
                    flush_cnt <= '0;
                    state     <= ST_RUN;
                end
                default: begin
                    oEnAcc <= 1'b0;
                    state  <= ST_RUN;
                end
            endcase
        end
    end

endmodule
